// File: rtl/vending_pkg.sv
// Shared vending definitions: FSM state encoding, error codes and coin values.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SELECT = 3'd2,
    ST_EJECT  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STOCK = 2'b01;
  localparam logic [1:0] ERR_JAM   = 2'b10;

  localparam int unsigned COIN_BIG_VAL   = 2;
  localparam int unsigned COIN_SMALL_VAL = 1;

endpackage

// File: rtl/coin_stock_counter.sv
// Hopper stock counter: saturating reload plus single-coin decrement in the same cycle.
module coin_stock_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] qty,
  input  logic             dec,
  output logic [CNT_W-1:0] stock
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] next_c;

  // One extra bit catches reload overflow; decrement applied before saturating.
  always_comb begin
    sum_c  = {1'b0, stock} + (load ? {1'b0, qty} : '0);
    next_c = sum_c;
    if (dec && (sum_c != '0)) begin
      next_c = sum_c - SUM_W'(1);
    end
  end

  // Stock register, cleared on reset, clamped at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stock <= '0;
    end else begin
      stock <= next_c[CNT_W] ? '1 : next_c[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: stock check, BIG-first coin selection, sensor-confirmed ejection with jam timeout.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned AMT_W     = 6,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned EJECT_LEN = 4,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  output logic             ready,
  output logic             eject_big,
  output logic             eject_small,
  input  logic             coin_sensed,
  input  logic             load_big,
  input  logic             load_small,
  input  logic [CNT_W-1:0] load_qty,
  output logic [CNT_W-1:0] stock_big,
  output logic [CNT_W-1:0] stock_small,
  output logic [AMT_W-1:0] paid,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CAP_W  = AMT_W + CNT_W + 1;

  state_t            state;
  logic [AMT_W-1:0]  rem;
  logic              use_big;
  logic [TCNT_W-1:0] tcnt;

  logic              coin_event_c;
  logic              dec_big_c;
  logic              dec_small_c;
  logic              pick_big_c;
  logic              stock_fail_c;
  logic [AMT_W-1:0]  coin_val_c;
  logic [CAP_W-1:0]  cap_c;

  // Coin confirmation, selection and stock-sufficiency decode.
  always_comb begin
    coin_event_c = coin_sensed && ((state == ST_EJECT) || (state == ST_WAIT));
    dec_big_c    = coin_event_c && use_big;
    dec_small_c  = coin_event_c && !use_big;
    coin_val_c   = use_big ? AMT_W'(COIN_BIG_VAL) : AMT_W'(COIN_SMALL_VAL);
    pick_big_c   = (rem >= AMT_W'(COIN_BIG_VAL)) && (stock_big != '0);
    cap_c        = (CAP_W'(stock_big) << 1) + CAP_W'(stock_small);
    stock_fail_c = (CAP_W'(rem) > cap_c) || (rem[0] && (stock_small == '0));
  end

  coin_stock_counter #(.CNT_W(CNT_W)) u_big_stock (
    .clk   (clk),
    .rst   (rst),
    .load  (load_big),
    .qty   (load_qty),
    .dec   (dec_big_c),
    .stock (stock_big)
  );

  coin_stock_counter #(.CNT_W(CNT_W)) u_small_stock (
    .clk   (clk),
    .rst   (rst),
    .load  (load_small),
    .qty   (load_qty),
    .dec   (dec_small_c),
    .stock (stock_small)
  );

  // Payout FSM with registered handshake, motor and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ready       <= 1'b1;
      eject_big   <= 1'b0;
      eject_small <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      paid        <= '0;
      rem         <= '0;
      use_big     <= 1'b0;
      tcnt        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && ready) begin
            rem      <= amount;
            paid     <= '0;
            err_code <= ERR_NONE;
            ready    <= 1'b0;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (stock_fail_c) begin
            err_code <= ERR_STOCK;
            state    <= ST_ERR;
          end else begin
            state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (rem == '0) begin
            state <= ST_DONE;
          end else begin
            use_big     <= pick_big_c;
            eject_big   <= pick_big_c;
            eject_small <= !pick_big_c;
            tcnt        <= '0;
            state       <= ST_EJECT;
          end
        end
        ST_EJECT, ST_WAIT: begin
          if (coin_event_c) begin
            rem         <= rem - coin_val_c;
            paid        <= paid + coin_val_c;
            eject_big   <= 1'b0;
            eject_small <= 1'b0;
            state       <= ST_SELECT;
          end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            eject_big   <= 1'b0;
            eject_small <= 1'b0;
            err_code    <= ERR_JAM;
            state       <= ST_ERR;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
            if ((state == ST_EJECT) && (tcnt == TCNT_W'(EJECT_LEN - 1))) begin
              eject_big   <= 1'b0;
              eject_small <= 1'b0;
              state       <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          err   <= 1'b1;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a hopper/sensor model and eject monitor.
module tb_change_dispenser;

  localparam int unsigned AMT_W     = 6;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned EJECT_LEN = 4;
  localparam int unsigned TIMEOUT   = 1000;

  logic             clk;
  logic             rst;
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             ready;
  logic             eject_big;
  logic             eject_small;
  logic             coin_sensed;
  logic             load_big;
  logic             load_small;
  logic [CNT_W-1:0] load_qty;
  logic [CNT_W-1:0] stock_big;
  logic [CNT_W-1:0] stock_small;
  logic [AMT_W-1:0] paid;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  int checks   = 0;
  int failures = 0;

  // Request outcome, filled by do_req.
  bit got_done;
  bit got_err;
  int lat;

  // Eject monitor: 1 = BIG, 0 = SMALL, in order of pulse start.
  bit ej_seq[$];
  int ej_len[$];
  int run_len = 0;
  bit pb = 0;
  bit ps = 0;
  bit both_seen = 0;

  change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .EJECT_LEN(EJECT_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount), .ready(ready),
    .eject_big(eject_big), .eject_small(eject_small), .coin_sensed(coin_sensed),
    .load_big(load_big), .load_small(load_small), .load_qty(load_qty),
    .stock_big(stock_big), .stock_small(stock_small), .paid(paid),
    .done(done), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record eject pulse order and lengths away from the active edge.
  always @(negedge clk) begin
    if (eject_big && eject_small) both_seen = 1'b1;
    if (eject_big && !pb) ej_seq.push_back(1'b1);
    if (eject_small && !ps) ej_seq.push_back(1'b0);
    if (eject_big || eject_small) begin
      run_len++;
    end else if (run_len != 0) begin
      ej_len.push_back(run_len);
      run_len = 0;
    end
    pb = eject_big;
    ps = eject_small;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    ej_seq.delete();
    ej_len.delete();
    run_len = 0;
  endtask

  task automatic load(input bit big, input logic [CNT_W-1:0] q);
    load_big   = big;
    load_small = !big;
    load_qty   = q;
    step();
    load_big   = 1'b0;
    load_small = 1'b0;
    load_qty   = '0;
  endtask

  function automatic int seq_code();
    int code = 0;
    foreach (ej_seq[i]) code = code * 2 + int'(ej_seq[i]);
    return code;
  endfunction

  // Issue one request and act as the hopper sensor until done/err or budget expiry.
  task automatic do_req(input logic [AMT_W-1:0] amt, input bit sense, input int dly,
                        input bit reload, input int budget);
    int c = 0;
    int first_c0 = -1;
    int sense_at = -1;
    bit pe = 1'b0;
    got_done = 1'b0;
    got_err  = 1'b0;
    lat      = -1;
    ej_seq.delete();
    ej_len.delete();
    req    = 1'b1;
    amount = amt;
    step();
    req = 1'b0;
    while (c <= budget) begin
      if (done) begin got_done = 1'b1; lat = c; break; end
      if (err)  begin got_err  = 1'b1; lat = c; break; end
      coin_sensed = 1'b0;
      load_big    = 1'b0;
      load_qty    = '0;
      if ((eject_big || eject_small) && !pe) begin
        if (first_c0 < 0) first_c0 = c;
        if (sense) sense_at = c + int'(EJECT_LEN) + dly;
      end
      pe = eject_big || eject_small;
      if (c == sense_at) coin_sensed = 1'b1;
      if (reload && (first_c0 >= 0) && (c == first_c0 + int'(EJECT_LEN))) begin
        load_big = 1'b1;
        load_qty = CNT_W'(2);
      end
      step();
      c++;
    end
    coin_sensed = 1'b0;
    load_big    = 1'b0;
    load_qty    = '0;
    if (!got_done && !got_err) check("req_terminated", 0, 1);
  endtask

  initial begin
    rst         = 1'b0;
    req         = 1'b0;
    amount      = '0;
    coin_sensed = 1'b0;
    load_big    = 1'b0;
    load_small  = 1'b0;
    load_qty    = '0;

    // Reset state
    apply_reset();
    check("rst_ready", ready, 1);
    check("rst_eject", {eject_big, eject_small}, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_err_code", err_code, 0);
    check("rst_paid", paid, 0);
    check("rst_stock_big", stock_big, 0);
    check("rst_stock_small", stock_small, 0);

    // 1: B=5,S=5, amount 5 -> B,B,S
    load(1'b1, 8'd5);
    load(1'b0, 8'd5);
    do_req(6'd5, 1'b1, 1, 1'b0, 200);
    check("t1_done", got_done, 1);
    check("t1_ready", ready, 1);
    check("t1_num_ejects", ej_seq.size(), 3);
    check("t1_order", seq_code(), 6);
    check("t1_pulse_len", (ej_len.size() > 0) ? ej_len[0] : 0, EJECT_LEN);
    check("t1_paid", paid, 5);
    check("t1_stock_big", stock_big, 3);
    check("t1_stock_small", stock_small, 4);
    check("t1_err_code", err_code, 0);
    check("t1_no_overlap", both_seen, 0);

    // 2: B=0,S=2, amount 3 -> insufficient stock
    apply_reset();
    load(1'b0, 8'd2);
    do_req(6'd3, 1'b1, 1, 1'b0, 50);
    check("t2_err", got_err, 1);
    check("t2_err_lat", lat, 2);
    check("t2_err_code", err_code, 1);
    check("t2_no_eject", ej_seq.size(), 0);
    check("t2_stock", {stock_big, stock_small}, {8'd0, 8'd2});

    // 3: B=2,S=0, amount 3 -> parity failure
    apply_reset();
    load(1'b1, 8'd2);
    do_req(6'd3, 1'b1, 1, 1'b0, 50);
    check("t3_err", got_err, 1);
    check("t3_err_code", err_code, 1);
    check("t3_no_eject", ej_seq.size(), 0);

    // 4: B=3,S=3, amount 4, sensor silent -> jam
    apply_reset();
    load(1'b1, 8'd3);
    load(1'b0, 8'd3);
    do_req(6'd4, 1'b0, 0, 1'b0, TIMEOUT + 50);
    check("t4_err", got_err, 1);
    check("t4_err_lat", lat, TIMEOUT + 3);
    check("t4_err_code", err_code, 2);
    check("t4_paid", paid, 0);
    check("t4_stock_big", stock_big, 3);
    check("t4_one_eject", ej_seq.size(), 1);

    // 5: B=1,S=3, amount 4, reload BIG by 2 during first WAIT -> B,B
    apply_reset();
    load(1'b1, 8'd1);
    load(1'b0, 8'd3);
    do_req(6'd4, 1'b1, 2, 1'b1, 200);
    check("t5_done", got_done, 1);
    check("t5_order", seq_code(), 3);
    check("t5_num_ejects", ej_seq.size(), 2);
    check("t5_stock_big", stock_big, 1);
    check("t5_stock_small", stock_small, 3);
    check("t5_paid", paid, 4);

    // 6a: amount 0 -> done 3 cycles after accept, no eject
    do_req(6'd0, 1'b1, 1, 1'b0, 50);
    check("t6_done", got_done, 1);
    check("t6_done_lat", lat, 3);
    check("t6_no_eject", ej_seq.size(), 0);
    check("t6_paid", paid, 0);

    // 6b: reset during EJECT
    load(1'b1, 8'd5);
    req    = 1'b1;
    amount = 6'd5;
    step();
    req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (eject_big || eject_small) break;
      step();
    end
    check("t6_in_eject", eject_big || eject_small, 1);
    rst = 1'b0;
    step();
    check("t6_rst_eject", {eject_big, eject_small}, 0);
    check("t6_rst_ready", ready, 1);
    check("t6_rst_stock", {stock_big, stock_small}, 0);
    rst = 1'b1;
    step();

    // Reload saturation at the counter limit
    load(1'b1, 8'd250);
    load(1'b1, 8'd10);
    check("sat_stock_big", stock_big, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
